// File: rtl/ldm_stm_mem_addr_generator.sv
// LDM/STM memory address sequencer: emits ascending word addresses for a block transfer.
// Define LDM_STM_ALIGN_CHECK_EN to fault on a misaligned base instead of truncating it.
module ldm_stm_mem_addr_generator (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        ldm_stm_start_in,
    input  logic [15:0] reg_list_in,
    input  logic [31:0] base_addr_in,
    input  logic        pre_index_in,
    input  logic        up_in,
    input  logic        writeback_in,
    input  logic        mem_ready_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_addr_valid_out,
    output logic [31:0] wb_addr_out,
    output logic        wb_en_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        align_fault_out
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  n_regs, remaining;
    logic [31:0] base, n_bytes, first_addr, wb_calc;
    logic [31:0] addr_q, wb_q;
    logic        wb_pend, fault, start_go;

    always_comb begin
        n_regs = '0;
        for (int i = 0; i < 16; i++)
            n_regs = n_regs + 5'(reg_list_in[i]);
    end

`ifdef LDM_STM_ALIGN_CHECK_EN
    assign base  = base_addr_in;
    assign fault = |base_addr_in[1:0];
`else
    assign base  = base_addr_in & ~32'd3;
    assign fault = 1'b0;
`endif

    assign n_bytes  = {25'd0, n_regs, 2'b00};
    assign start_go = (state == IDLE) && ldm_stm_start_in;

    // Descending modes still walk upward from the lowest address of the block.
    always_comb begin
        case ({pre_index_in, up_in})
            2'b01:   first_addr = base;
            2'b11:   first_addr = base + 32'd4;
            2'b00:   first_addr = base - n_bytes + 32'd4;
            default: first_addr = base - n_bytes;
        endcase
        wb_calc = up_in ? (base + n_bytes) : (base - n_bytes);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ldm_stm_start_in)
                      state_nxt = (fault || n_regs == 5'd0) ? DONE : XFER;
            XFER: if (mem_ready_in && remaining == 5'd1)
                      state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            wb_q      <= '0;
            wb_pend   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_go) begin
                addr_q    <= first_addr;
                remaining <= n_regs;
                wb_q      <= wb_calc;
                wb_pend   <= writeback_in && (n_regs != 5'd0) && !fault;
            end else if (state == XFER && mem_ready_in) begin
                addr_q    <= addr_q + 32'd4;
                remaining <= remaining - 5'd1;
            end
        end
    end

`ifdef LDM_STM_ALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)     fault_q <= 1'b0;
        else if (start_go) fault_q <= fault;
    end
    assign align_fault_out = (state == DONE) && fault_q;
`else
    assign align_fault_out = 1'b0;
`endif

    assign mem_addr_out       = addr_q;
    assign mem_addr_valid_out = (state == XFER);
    assign wb_addr_out        = wb_q;
    assign wb_en_out          = (state == DONE) && wb_pend;
    assign busy_out           = (state != IDLE);
    assign done_out           = (state == DONE);

endmodule

// File: tb/tb_ldm_stm_mem_addr_generator.sv
// Directed bench for ldm_stm_mem_addr_generator; hand-computed addresses per transfer mode.
module tb_ldm_stm_mem_addr_generator;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        ldm_stm_start_in = 1'b0;
    logic [15:0] reg_list_in = '0;
    logic [31:0] base_addr_in = '0;
    logic        pre_index_in = 1'b0, up_in = 1'b0, writeback_in = 1'b0;
    logic        mem_ready_in = 1'b0;
    logic [31:0] mem_addr_out, wb_addr_out;
    logic        mem_addr_valid_out, wb_en_out, busy_out, done_out, align_fault_out;

    int tests = 0;
    int fails = 0;

    ldm_stm_mem_addr_generator dut (
        .clk_in(clk_in), .reset_in(reset_in), .ldm_stm_start_in(ldm_stm_start_in),
        .reg_list_in(reg_list_in), .base_addr_in(base_addr_in),
        .pre_index_in(pre_index_in), .up_in(up_in), .writeback_in(writeback_in),
        .mem_ready_in(mem_ready_in), .mem_addr_out(mem_addr_out),
        .mem_addr_valid_out(mem_addr_valid_out), .wb_addr_out(wb_addr_out),
        .wb_en_out(wb_en_out), .busy_out(busy_out), .done_out(done_out),
        .align_fault_out(align_fault_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Presents one start pulse; returns sampled in cycle 1 (first valid cycle).
    task automatic start_op(input logic [31:0] base, input logic [15:0] list,
                            input logic p, input logic u, input logic w);
        base_addr_in = base; reg_list_in = list;
        pre_index_in = p; up_in = u; writeback_in = w;
        ldm_stm_start_in = 1'b1;
        tick();
        ldm_stm_start_in = 1'b0;
    endtask

    task automatic chk_xfer(input string tag, input logic [31:0] addr);
        chk({tag, "_valid"}, {31'd0, mem_addr_valid_out}, 32'd1);
        chk({tag, "_addr"}, mem_addr_out, addr);
        chk({tag, "_done"}, {31'd0, done_out}, 32'd0);
    endtask

    task automatic chk_done(input string tag, input logic wb_en, input logic [31:0] wb);
        chk({tag, "_done"}, {31'd0, done_out}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy_out}, 32'd1);
        chk({tag, "_valid"}, {31'd0, mem_addr_valid_out}, 32'd0);
        chk({tag, "_wb_en"}, {31'd0, wb_en_out}, {31'd0, wb_en});
        chk({tag, "_wb_addr"}, wb_addr_out, wb);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_flags", {26'd0, mem_addr_valid_out, wb_en_out, busy_out, done_out,
                          align_fault_out, 1'b0}, 32'd0);
        chk("rst_wb", wb_addr_out, 32'd0);
        reset_in = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy_out}, 32'd0);

        // IA with writeback
        mem_ready_in = 1'b1;
        start_op(32'h1000, 16'h000B, 1'b0, 1'b1, 1'b1);
        chk("ia_busy", {31'd0, busy_out}, 32'd1);
        chk_xfer("ia0", 32'h1000);
        tick(); chk_xfer("ia1", 32'h1004);
        tick(); chk_xfer("ia2", 32'h1008);
        tick(); chk_done("ia", 1'b1, 32'h100C);
        tick();
        chk("ia_after_done", {30'd0, busy_out, done_out}, 32'd0);
        chk("ia_wb_hold", wb_addr_out, 32'h100C);

        // DB with writeback
        start_op(32'h2000, 16'h8001, 1'b1, 1'b0, 1'b1);
        chk_xfer("db0", 32'h1FF8);
        tick(); chk_xfer("db1", 32'h1FFC);
        tick(); chk_done("db", 1'b1, 32'h1FF8);
        tick();

        // IB with a stall in the first transfer cycle
        mem_ready_in = 1'b0;
        start_op(32'h0, 16'h0003, 1'b1, 1'b1, 1'b0);
        chk_xfer("ib_stall0", 32'h4);
        tick(); chk_xfer("ib_stall1", 32'h4);
        mem_ready_in = 1'b1;
        tick(); chk_xfer("ib1", 32'h8);
        tick(); chk_done("ib", 1'b0, 32'h8);
        tick();

        // Empty list: straight to DONE, no writeback even with W=1
        start_op(32'h500, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk_done("empty", 1'b0, 32'h500);
        tick();
        chk("empty_idle", {31'd0, busy_out}, 32'd0);

        // IA wrapping past 2^32
        start_op(32'hFFFF_FFFC, 16'h0003, 1'b0, 1'b1, 1'b0);
        chk_xfer("wrap0", 32'hFFFF_FFFC);
        tick(); chk_xfer("wrap1", 32'h0000_0000);
        tick(); chk_done("wrap", 1'b0, 32'h4);
        tick();

        // DA, with a second start during XFER that must be ignored
        start_op(32'h100, 16'h0070, 1'b0, 1'b0, 1'b1);
        chk_xfer("da0", 32'hF8);
        base_addr_in = 32'h9000; reg_list_in = 16'h0001; up_in = 1'b1;
        ldm_stm_start_in = 1'b1;
        tick(); ldm_stm_start_in = 1'b0;
        chk_xfer("da1", 32'hFC);
        tick(); chk_xfer("da2", 32'h100);
        tick(); chk_done("da", 1'b1, 32'hF4);
        tick();

        // Misaligned base
`ifdef LDM_STM_ALIGN_CHECK_EN
        start_op(32'h1002, 16'h0001, 1'b0, 1'b1, 1'b1);
        chk_done("align", 1'b0, wb_addr_out);
        chk("align_fault", {31'd0, align_fault_out}, 32'd1);
        tick();
        chk("align_fault_clr", {31'd0, align_fault_out}, 32'd0);
`else
        start_op(32'h1002, 16'h0001, 1'b0, 1'b1, 1'b1);
        chk_xfer("trunc0", 32'h1000);
        chk("trunc_fault", {31'd0, align_fault_out}, 32'd0);
        tick(); chk_done("trunc", 1'b1, 32'h1004);
        tick();
`endif

        // Reset mid-transfer on a full register list
        start_op(32'h3000, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        chk_xfer("full0", 32'h3000);
        tick(); chk_xfer("full1", 32'h3004);
        #2 reset_in = 1'b0;
        #1;
        chk("mid_rst_addr", mem_addr_out, 32'd0);
        chk("mid_rst_wb", wb_addr_out, 32'd0);
        chk("mid_rst_flags", {27'd0, mem_addr_valid_out, wb_en_out, busy_out, done_out,
                              align_fault_out}, 32'd0);
        tick(); tick();
        chk("rst_hold_done", {30'd0, done_out, wb_en_out}, 32'd0);
        #3 reset_in = 1'b1;
        tick();
        chk("post_rst_flags", {29'd0, mem_addr_valid_out, busy_out, done_out}, 32'd0);

        // Post-reset operation works normally
        start_op(32'h40, 16'h0001, 1'b1, 1'b1, 1'b1);
        chk_xfer("post0", 32'h44);
        tick(); chk_done("post", 1'b1, 32'h44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
